// File: rtl/axi_channel_pipeline.sv
// axi_channel_pipeline: cascaded valid/ready register slice for one AXI channel.
// REG_TYPE selects bypass (0), simple one-entry buffers (1) or two-entry
// skid buffers (2). Adds a synchronous flush and a live occupancy count.
`timescale 1ns/1ps

module axi_channel_pipeline #(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 2,
    parameter int REG_TYPE    = 2,
    parameter int COUNT_WIDTH = $clog2(2*STAGES+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] count
);

    generate
        if (REG_TYPE == 0) begin : g_bypass
            // Pure wires: nothing is held, so clock, reset and flush play no part.
            logic bypass_unused;
            assign bypass_unused = clk ^ rst_n ^ flush;

            assign m_data  = s_data;
            assign m_valid = s_valid;
            assign s_ready = m_ready;
            assign count   = '0;
        end else begin : g_pipe
            // Link k carries the output of stage k-1 into stage k; link STAGES is the master side.
            logic [STAGES:1]  link_valid;
            logic [STAGES:0]  link_ready;
            logic [WIDTH-1:0] link_data [0:STAGES];

            logic                   init_reg;
            logic [COUNT_WIDTH-1:0] count_reg;
            logic                   in_xfer;
            logic                   out_xfer;

            // Upstream ready is withheld until the first edge after reset and during flush.
            assign s_ready            = link_ready[0] && init_reg && !flush;
            assign in_xfer            = s_valid && s_ready;
            assign link_data[0]       = s_data;
            assign link_ready[STAGES] = m_ready;
            // Gating with flush keeps a discarded beat from being seen as a handshake.
            assign m_valid            = link_valid[STAGES] && !flush;
            assign m_data             = link_data[STAGES];
            assign out_xfer           = m_valid && m_ready;
            assign count              = count_reg;

            // Marks that the first edge after reset release has happened.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    init_reg <= 1'b0;
                end else begin
                    init_reg <= 1'b1;
                end
            end

            // Occupancy: internal moves conserve entries, so only the end handshakes matter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (flush) begin
                    count_reg <= '0;
                end else if (in_xfer && !out_xfer) begin
                    count_reg <= count_reg + COUNT_WIDTH'(1);
                end else if (!in_xfer && out_xfer) begin
                    count_reg <= count_reg - COUNT_WIDTH'(1);
                end
            end

            genvar gi;
            for (gi = 0; gi < STAGES; gi++) begin : g_stage
                logic stage_in_valid;

                // Stage 0 sees the qualified upstream handshake; later stages see the previous valid.
                if (gi == 0) begin : g_first
                    assign stage_in_valid = in_xfer;
                end else begin : g_inner
                    assign stage_in_valid = link_valid[gi];
                end

                if (REG_TYPE == 1) begin : g_simple
                    logic             valid_reg;
                    logic [WIDTH-1:0] data_reg;

                    assign link_ready[gi]   = !valid_reg;
                    assign link_valid[gi+1] = valid_reg;
                    assign link_data[gi+1]  = data_reg;

                    // Fill only when empty, empty when the next stage takes the entry.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            valid_reg <= 1'b0;
                            data_reg  <= '0;
                        end else if (flush) begin
                            valid_reg <= 1'b0;
                        end else if (stage_in_valid && !valid_reg) begin
                            valid_reg <= 1'b1;
                            data_reg  <= link_data[gi];
                        end else if (valid_reg && link_ready[gi+1]) begin
                            valid_reg <= 1'b0;
                        end
                    end
                end else begin : g_skid
                    logic             out_valid_reg, out_valid_next;
                    logic [WIDTH-1:0] out_data_reg,  out_data_next;
                    logic             tmp_valid_reg, tmp_valid_next;
                    logic [WIDTH-1:0] tmp_data_reg,  tmp_data_next;
                    logic             ready_reg;
                    logic             in_fire;

                    assign in_fire          = stage_in_valid && ready_reg;
                    assign link_ready[gi]   = ready_reg;
                    assign link_valid[gi+1] = out_valid_reg;
                    assign link_data[gi+1]  = out_data_reg;

                    // Output slot refills from temp first (older beat), otherwise from the input;
                    // an input arriving while the output is stuck lands in temp.
                    always_comb begin
                        out_valid_next = out_valid_reg;
                        out_data_next  = out_data_reg;
                        tmp_valid_next = tmp_valid_reg;
                        tmp_data_next  = tmp_data_reg;
                        if (!out_valid_reg || link_ready[gi+1]) begin
                            if (tmp_valid_reg) begin
                                out_valid_next = 1'b1;
                                out_data_next  = tmp_data_reg;
                                tmp_valid_next = in_fire;
                                if (in_fire) begin
                                    tmp_data_next = link_data[gi];
                                end
                            end else begin
                                out_valid_next = in_fire;
                                if (in_fire) begin
                                    out_data_next = link_data[gi];
                                end
                            end
                        end else if (in_fire) begin
                            tmp_valid_next = 1'b1;
                            tmp_data_next  = link_data[gi];
                        end
                        if (flush) begin
                            out_valid_next = 1'b0;
                            tmp_valid_next = 1'b0;
                        end
                    end

                    // Register the stage; ready is a flop so m_ready never reaches s_ready.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            out_valid_reg <= 1'b0;
                            out_data_reg  <= '0;
                            tmp_valid_reg <= 1'b0;
                            tmp_data_reg  <= '0;
                            ready_reg     <= 1'b0;
                        end else begin
                            out_valid_reg <= out_valid_next;
                            out_data_reg  <= out_data_next;
                            tmp_valid_reg <= tmp_valid_next;
                            tmp_data_reg  <= tmp_data_next;
                            ready_reg     <= !tmp_valid_next;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axi_channel_pipeline.sv
// Testbench for axi_channel_pipeline: several configurations, each exercised by
// its own task against a queue-based reference of the in-order channel.
`timescale 1ns/1ps

module tb_axi_channel_pipeline;
    localparam int W   = 32;
    localparam int CWA = $clog2(2*3+1);
    localparam int CWB = $clog2(2*2+1);
    localparam int CWC = $clog2(2*4+1);
    localparam int CWD = $clog2(2*2+1);
    localparam int CWE = $clog2(2*5+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks_total  = 0;
    int checks_passed = 0;

    // a: skid, 3 stages
    logic a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [W-1:0] a_s_data, a_m_data;
    logic [CWA-1:0] a_count;
    // b: skid, 2 stages
    logic b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [W-1:0] b_s_data, b_m_data;
    logic [CWB-1:0] b_count;
    // c: simple buffer, 4 stages
    logic c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [W-1:0] c_s_data, c_m_data;
    logic [CWC-1:0] c_count;
    // d: bypass
    logic d_flush, d_s_valid, d_s_ready, d_m_valid, d_m_ready;
    logic [W-1:0] d_s_data, d_m_data;
    logic [CWD-1:0] d_count;
    // e: skid, 5 stages
    logic e_flush, e_s_valid, e_s_ready, e_m_valid, e_m_ready;
    logic [W-1:0] e_s_data, e_m_data;
    logic [CWE-1:0] e_count;

    axi_channel_pipeline #(.WIDTH(W), .STAGES(3), .REG_TYPE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .s_data(a_s_data), .s_valid(a_s_valid),
        .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .count(a_count));
    axi_channel_pipeline #(.WIDTH(W), .STAGES(2), .REG_TYPE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .s_data(b_s_data), .s_valid(b_s_valid),
        .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .count(b_count));
    axi_channel_pipeline #(.WIDTH(W), .STAGES(4), .REG_TYPE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .s_data(c_s_data), .s_valid(c_s_valid),
        .s_ready(c_s_ready), .m_data(c_m_data), .m_valid(c_m_valid), .m_ready(c_m_ready), .count(c_count));
    axi_channel_pipeline #(.WIDTH(W), .STAGES(2), .REG_TYPE(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .s_data(d_s_data), .s_valid(d_s_valid),
        .s_ready(d_s_ready), .m_data(d_m_data), .m_valid(d_m_valid), .m_ready(d_m_ready), .count(d_count));
    axi_channel_pipeline #(.WIDTH(W), .STAGES(5), .REG_TYPE(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(e_flush), .s_data(e_s_data), .s_valid(e_s_valid),
        .s_ready(e_s_ready), .m_data(e_m_data), .m_valid(e_m_valid), .m_ready(e_m_ready), .count(e_count));

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks_total++; if (a_m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", a_m_valid); else checks_passed++;
        checks_total++; if (a_s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", a_s_ready); else checks_passed++;
        checks_total++; if (a_count !== '0) $display("FAIL reset_count: got %0d want 0", a_count); else checks_passed++;
        checks_total++; if (a_m_data !== '0) $display("FAIL reset_m_data: got %0h want 0", a_m_data); else checks_passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++; if (a_s_ready !== 1'b0) $display("FAIL release_s_ready_pre: got %b want 0", a_s_ready); else checks_passed++;
        checks_total++; if (c_s_ready !== 1'b0) $display("FAIL release_t1_ready_pre: got %b want 0", c_s_ready); else checks_passed++;
        @(posedge clk); #1;
        checks_total++; if (a_s_ready !== 1'b1) $display("FAIL release_s_ready_post: got %b want 1", a_s_ready); else checks_passed++;
        checks_total++; if (c_s_ready !== 1'b1) $display("FAIL release_t1_ready_post: got %b want 1", c_s_ready); else checks_passed++;
        $display("reset: released, s_ready=%b count=%0d", a_s_ready, a_count);
    endtask

    task automatic test_streaming();
        int in_n = 0, out_n = 0, acc_it = -1, first_it = -1, bubbles = 0, in_stalls = 0;
        a_m_ready = 1'b1;
        for (int it = 0; it < 400 && out_n < 100; it++) begin
            a_s_valid = (in_n < 100);
            a_s_data  = W'(in_n);
            @(negedge clk);
            if (a_m_valid && in_n < 100 && in_n >= 3) begin
                checks_total++; if (a_count !== CWA'(3)) $display("FAIL stream_count: got %0d want 3", a_count); else checks_passed++;
            end
            if (a_m_valid) begin
                if (first_it < 0) first_it = it;
                checks_total++; if (a_m_data !== W'(out_n)) $display("FAIL stream_data: got %0h want %0h", a_m_data, out_n); else checks_passed++;
                $display("stream: out beat %0d data %0h", out_n, a_m_data);
                out_n++;
            end else if (first_it >= 0) begin
                bubbles++;
            end
            if (a_s_valid && a_s_ready) begin
                if (in_n == 0) acc_it = it;
                in_n++;
            end else if (a_s_valid) begin
                in_stalls++;
            end
            @(posedge clk); #1;
        end
        a_s_valid = 1'b0;
        checks_total++; if (out_n !== 100) $display("FAIL stream_total: got %0d want 100", out_n); else checks_passed++;
        checks_total++; if (first_it - acc_it !== 3) $display("FAIL stream_latency: got %0d want 3", first_it - acc_it); else checks_passed++;
        checks_total++; if (bubbles !== 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles); else checks_passed++;
        checks_total++; if (in_stalls !== 0) $display("FAIL stream_in_stalls: got %0d want 0", in_stalls); else checks_passed++;
    endtask

    task automatic test_fill_drain();
        int in_n = 0, out_n = 0;
        b_m_ready = 1'b0;
        for (int it = 0; it < 10; it++) begin
            b_s_valid = 1'b1;
            b_s_data  = 32'h100 + W'(in_n);
            @(negedge clk);
            if (b_s_valid && b_s_ready) in_n++;
            @(posedge clk); #1;
        end
        b_s_data = 32'h100 + W'(in_n);
        @(negedge clk);
        checks_total++; if (in_n !== 4) $display("FAIL fill_accepted: got %0d want 4", in_n); else checks_passed++;
        checks_total++; if (b_count !== CWB'(4)) $display("FAIL fill_count: got %0d want 4", b_count); else checks_passed++;
        checks_total++; if (b_s_ready !== 1'b0) $display("FAIL fill_s_ready: got %b want 0", b_s_ready); else checks_passed++;
        $display("fill: accepted %0d count %0d", in_n, b_count);
        if (b_s_valid && b_s_ready) in_n++;
        @(posedge clk); #1;
        b_m_ready = 1'b1;
        for (int it = 0; it < 80 && out_n < 10; it++) begin
            b_s_valid = (in_n < 10);
            b_s_data  = 32'h100 + W'(in_n);
            @(negedge clk);
            if (it < 4) begin
                checks_total++; if (b_m_valid !== 1'b1) $display("FAIL drain_consecutive: cycle %0d m_valid %b want 1", it, b_m_valid); else checks_passed++;
            end
            if (b_m_valid && b_m_ready) begin
                checks_total++; if (b_m_data !== 32'h100 + W'(out_n)) $display("FAIL drain_data: got %0h want %0h", b_m_data, 32'h100 + out_n); else checks_passed++;
                $display("drain: out beat %0d data %0h", out_n, b_m_data);
                out_n++;
            end
            if (b_s_valid && b_s_ready) in_n++;
            @(posedge clk); #1;
        end
        b_s_valid = 1'b0;
        checks_total++; if (out_n !== 10) $display("FAIL drain_total: got %0d want 10", out_n); else checks_passed++;
    endtask

    task automatic test_half_throughput();
        int in_n = 0, out_n = 0, last_acc = -1;
        c_m_ready = 1'b1;
        for (int it = 0; it < 200 && out_n < 20; it++) begin
            c_s_valid = (in_n < 20);
            c_s_data  = 32'h200 + W'(in_n);
            @(negedge clk);
            checks_total++; if (int'(c_count) !== in_n - out_n) $display("FAIL half_count: got %0d want %0d", c_count, in_n - out_n); else checks_passed++;
            checks_total++; if (int'(c_count) > 4) $display("FAIL half_count_cap: got %0d want <=4", c_count); else checks_passed++;
            if (c_m_valid && c_m_ready) begin
                checks_total++; if (c_m_data !== 32'h200 + W'(out_n)) $display("FAIL half_data: got %0h want %0h", c_m_data, 32'h200 + out_n); else checks_passed++;
                $display("half: out beat %0d data %0h", out_n, c_m_data);
                out_n++;
            end
            if (c_s_valid && c_s_ready) begin
                if (last_acc >= 0) begin
                    checks_total++; if (it - last_acc !== 2) $display("FAIL half_gap: got %0d want 2", it - last_acc); else checks_passed++;
                end
                last_acc = it;
                in_n++;
            end
            @(posedge clk); #1;
        end
        c_s_valid = 1'b0;
        checks_total++; if (out_n !== 20) $display("FAIL half_total: got %0d want 20", out_n); else checks_passed++;
    endtask

    task automatic test_flush();
        int in_n = 0, seen = -1, outs = 0;
        b_m_ready = 1'b0;
        for (int it = 0; it < 20 && in_n < 3; it++) begin
            b_s_valid = 1'b1;
            b_s_data  = 32'h300 + W'(in_n);
            @(negedge clk);
            if (b_s_valid && b_s_ready) in_n++;
            @(posedge clk); #1;
        end
        b_s_valid = 1'b0;
        @(negedge clk);
        checks_total++; if (b_count !== CWB'(3)) $display("FAIL flush_pre_count: got %0d want 3", b_count); else checks_passed++;
        @(posedge clk); #1;
        b_flush = 1'b1; b_s_valid = 1'b1; b_s_data = 32'h3FF; b_m_ready = 1'b1;
        @(negedge clk);
        checks_total++; if (b_s_ready !== 1'b0) $display("FAIL flush_s_ready: got %b want 0", b_s_ready); else checks_passed++;
        @(posedge clk); #1;
        b_flush = 1'b0; b_s_valid = 1'b0;
        @(negedge clk);
        checks_total++; if (b_count !== '0) $display("FAIL flush_count: got %0d want 0", b_count); else checks_passed++;
        checks_total++; if (b_m_valid !== 1'b0) $display("FAIL flush_m_valid: got %b want 0", b_m_valid); else checks_passed++;
        $display("flush: count %0d m_valid %b", b_count, b_m_valid);
        @(posedge clk); #1;
        b_s_valid = 1'b1; b_s_data = 32'hA5;
        @(negedge clk);
        checks_total++; if (b_s_ready !== 1'b1) $display("FAIL flush_ready_after: got %b want 1", b_s_ready); else checks_passed++;
        @(posedge clk); #1;
        b_s_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (b_m_valid) begin
                outs++;
                if (seen < 0) begin
                    seen = k;
                    checks_total++; if (b_m_data !== 32'hA5) $display("FAIL flush_next_data: got %0h want a5", b_m_data); else checks_passed++;
                end
            end
            @(posedge clk); #1;
        end
        checks_total++; if (seen !== 2) $display("FAIL flush_next_latency: got %0d want 2", seen); else checks_passed++;
        checks_total++; if (outs !== 1) $display("FAIL flush_out_beats: got %0d want 1", outs); else checks_passed++;
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 8; i++) begin
            d_s_data  = $urandom;
            d_s_valid = 1'($urandom_range(0, 1));
            d_m_ready = 1'($urandom_range(0, 1));
            d_flush   = 1'($urandom_range(0, 1));
            #1;
            checks_total++; if (d_m_data !== d_s_data) $display("FAIL bypass_data: got %0h want %0h", d_m_data, d_s_data); else checks_passed++;
            checks_total++; if (d_m_valid !== d_s_valid) $display("FAIL bypass_valid: got %b want %b", d_m_valid, d_s_valid); else checks_passed++;
            checks_total++; if (d_s_ready !== d_m_ready) $display("FAIL bypass_ready: got %b want %b", d_s_ready, d_m_ready); else checks_passed++;
            checks_total++; if (d_count !== '0) $display("FAIL bypass_count: got %0d want 0", d_count); else checks_passed++;
            $display("bypass: s=%0h/%b m_ready=%b -> m=%0h/%b", d_s_data, d_s_valid, d_m_ready, d_m_data, d_m_valid);
        end
        d_flush = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] model_q[$];
        logic [W-1:0] want, prev_data = '0;
        logic [W-1:0] next_data = $urandom;
        int in_n = 0, out_n = 0;
        bit prev_stall = 1'b0;
        for (int it = 0; it < 60000 && out_n < 10000; it++) begin
            e_s_valid = (in_n < 10000) && ($urandom_range(0, 1) == 1);
            e_s_data  = next_data;
            e_m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks_total++; if (int'(e_count) !== model_q.size()) $display("FAIL rand_count: got %0d want %0d", e_count, model_q.size()); else checks_passed++;
            if (prev_stall) begin
                checks_total++; if ({e_m_valid, e_m_data} !== {1'b1, prev_data}) $display("FAIL rand_stable: got %b/%0h want 1/%0h", e_m_valid, e_m_data, prev_data); else checks_passed++;
            end
            prev_stall = e_m_valid && !e_m_ready;
            prev_data  = e_m_data;
            if (e_m_valid && e_m_ready) begin
                want = (model_q.size() > 0) ? model_q.pop_front() : 'x;
                checks_total++; if (e_m_data !== want) $display("FAIL rand_data: beat %0d got %0h want %0h", out_n, e_m_data, want); else checks_passed++;
                out_n++;
            end
            if (e_s_valid && e_s_ready) begin
                model_q.push_back(e_s_data);
                next_data = $urandom;
                in_n++;
            end
            @(posedge clk); #1;
        end
        e_s_valid = 1'b0;
        checks_total++; if (out_n !== 10000) $display("FAIL rand_total: got %0d want 10000", out_n); else checks_passed++;
        $display("random: %0d beats in, %0d beats out", in_n, out_n);
    endtask

    initial begin
        rst_n = 1'b0;
        {a_flush, a_s_valid, a_m_ready} = '0; a_s_data = '0;
        {b_flush, b_s_valid, b_m_ready} = '0; b_s_data = '0;
        {c_flush, c_s_valid, c_m_ready} = '0; c_s_data = '0;
        {d_flush, d_s_valid, d_m_ready} = '0; d_s_data = '0;
        {e_flush, e_s_valid, e_m_ready} = '0; e_s_data = '0;
        test_reset();
        test_streaming();
        test_fill_drain();
        test_half_throughput();
        test_flush();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
